// File: rtl/scan_chain_ctrl_if.sv
// Host-side handshake for the scan-chain controller: operation request and
// pattern in, status and read-back data out.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
) ();
    logic                 start;
    logic                 skip_reset;
    logic [CHAIN_LEN-1:0] pattern;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] capture;

    modport master (
        output start, skip_reset, pattern,
        input  busy, done, capture
    );

    modport slave (
        input  start, skip_reset, pattern,
        output busy, done, capture
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-chain loader/reader: divided scan clock, optional chain-reset pulse,
// LSB-first shift-in of a pattern with simultaneous capture of the old contents.
module scan_chain_ctrl #(
    parameter int   CHAIN_LEN   = 8,
    parameter int   DIV_LOG2    = 7,
    parameter int   RESET_TICKS = 11,
    parameter logic IDLE_DIN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    scan_chain_ctrl_if.slave    host,
    input  logic                scan_sout,
    output logic                scan_clk,
    output logic                scan_din,
    output logic                scan_reset,
    output logic [2:0]          state
);
    localparam int IDX_W = $clog2(CHAIN_LEN + 1);
    localparam int RST_W = $clog2(RESET_TICKS + 1);
    localparam logic [DIV_LOG2-1:0] RISE_CNT = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    state_t               st;
    logic [DIV_LOG2-1:0]  div_cnt;
    logic [DIV_LOG2-1:0]  div_nxt;
    logic                 fall_tick;
    logic                 rise_tick;
    logic                 start_d;
    logic                 start_rise;
    logic                 start_ok;
    logic                 start_pend;
    logic                 accept;
    logic                 busy_q;
    logic                 done_q;
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CHAIN_LEN-1:0] sh_q;
    logic [IDX_W-1:0]     idx;
    logic [RST_W-1:0]     rst_cnt;

    assign div_nxt   = div_cnt + DIV_LOG2'(1);
    assign fall_tick = (div_cnt == '1);
    assign rise_tick = (div_cnt == RISE_CNT);

    assign start_rise = host.start & ~start_d;
    // The DONE->IDLE edge still shows busy=1, yet an edge there must be kept.
    assign start_ok   = ~busy_q | (fall_tick & (st == ST_DONE));
    assign accept     = fall_tick & (st == ST_IDLE) & start_pend;

    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.capture = cap_q;
    assign state        = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_clk <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            scan_clk <= div_nxt[DIV_LOG2-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d    <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            start_d <= host.start;
            if (accept)
                start_pend <= 1'b0;
            else if (start_rise && start_ok)
                start_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            scan_din   <= IDLE_DIN;
            scan_reset <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cap_q      <= '0;
            sh_q       <= '0;
            idx        <= '0;
            rst_cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            // idx counts bits already driven; no sample until bit 0 is on the pin.
            if (rise_tick && st == ST_SHIFT && idx != '0)
                cap_q <= (cap_q >> 1) | (CHAIN_LEN'(scan_sout) << (CHAIN_LEN - 1));
            if (fall_tick) begin
                case (st)
                    ST_IDLE: begin
                        scan_din   <= IDLE_DIN;
                        scan_reset <= 1'b0;
                        if (start_pend) begin
                            sh_q    <= host.pattern;
                            busy_q  <= 1'b1;
                            idx     <= '0;
                            rst_cnt <= '0;
                            st      <= host.skip_reset ? ST_SHIFT : ST_RESET;
                        end
                    end
                    ST_RESET: begin
                        if (rst_cnt == RST_W'(RESET_TICKS)) begin
                            scan_reset <= 1'b0;
                            scan_din   <= sh_q[0];
                            sh_q       <= sh_q >> 1;
                            idx        <= IDX_W'(1);
                            st         <= ST_SHIFT;
                        end else begin
                            scan_reset <= 1'b1;
                            rst_cnt    <= rst_cnt + RST_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        if (idx == IDX_W'(CHAIN_LEN)) begin
                            scan_din <= IDLE_DIN;
                            done_q   <= 1'b1;
                            st       <= ST_DONE;
                        end else begin
                            scan_din <= sh_q[0];
                            sh_q     <= sh_q >> 1;
                            idx      <= idx + IDX_W'(1);
                        end
                    end
                    ST_DONE: begin
                        busy_q <= 1'b0;
                        st     <= ST_IDLE;
                    end
                    default: begin
                        scan_din   <= IDLE_DIN;
                        scan_reset <= 1'b0;
                        busy_q     <= 1'b0;
                        st         <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Randomised bench for scan_chain_ctrl with a period-level timeline model and
// a behavioural 8-bit chain attached to the scan pins.
module tb_scan_chain_ctrl;
    localparam int C  = 8;
    localparam int DL = 2;
    localparam int RT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_sout;
    logic       scan_clk;
    logic       scan_din;
    logic       scan_reset;
    logic [2:0] state;
    logic [C-1:0] chain;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    scan_chain_ctrl_if #(.CHAIN_LEN(C)) hif ();

    scan_chain_ctrl #(
        .CHAIN_LEN  (C),
        .DIV_LOG2   (DL),
        .RESET_TICKS(RT),
        .IDLE_DIN   (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (hif.slave),
        .scan_sout (scan_sout),
        .scan_clk  (scan_clk),
        .scan_din  (scan_din),
        .scan_reset(scan_reset),
        .state     (state)
    );

    always #5 clk = ~clk;
    assign scan_sout = chain[0];

    always @(negedge clk) if (hif.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {busy, scan_reset, scan_din} in scan period k after acceptance.
    function automatic logic [2:0] exp_period(input int k, input bit skip, input logic [C-1:0] pat);
        int   first;
        logic b, r, d;
        first = skip ? 1 : RT + 1;
        b = (k <= first + C);
        r = !skip && k >= 1 && k <= RT;
        d = (k >= first && k < first + C) ? pat[k - first] : 1'b1;
        return {b, r, d};
    endfunction

    task automatic wait_rise(output bit ok);
        logic p;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            p = scan_clk;
            @(posedge clk); #1;
            if (!p && scan_clk) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_start();
        hif.start = 1'b1;
        @(posedge clk); #1;
        hif.start = 1'b0;
    endtask

    task automatic run_op(input logic [C-1:0] pat, input bit skip, input bit do_start,
                          input bit extra_edges, input bit chain_next, input int abort_bit);
        logic [C-1:0] exp_cap;
        bit ok;
        int first, ntot;
        exp_cap = chain;
        done_cnt = 0;
        hif.pattern = pat;
        hif.skip_reset = skip;
        if (do_start) begin
            @(negedge clk) hif.start = 1'b1;
            @(negedge clk) hif.start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (hif.busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("busy_rise", 32'(ok), 32'd1);
        if (!ok) return;
        first = skip ? 1 : RT + 1;
        ntot  = first + C + 1;
        for (int k = 0; k <= ntot; k++) begin
            wait_rise(ok);
            if (!ok) begin
                check("sclk_timeout", 32'd0, 32'd1);
                return;
            end
            check($sformatf("period%0d", k), {29'd0, hif.busy, scan_reset, scan_din},
                  {29'd0, exp_period(k, skip, pat)});
            if (k >= first && k < first + C)
                chain = {scan_din, chain[C-1:1]};
            if (abort_bit >= 0 && k == first + abort_bit) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs", {26'd0, scan_clk, scan_din, scan_reset, hif.busy, hif.done, state},
                      {26'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
                check("abort_cap", 32'(hif.capture), 32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (8) @(negedge clk);
                check("abort_no_done", done_cnt, 0);
                return;
            end
            if (extra_edges && k >= 2 && k <= 4)
                pulse_start();
            if (chain_next && k == ntot - 1) begin
                @(posedge clk); #1;
                pulse_start();
            end
        end
        check("done_cnt", done_cnt, 1);
        check("capture", 32'(hif.capture), 32'(exp_cap));
        check("state_idle", 32'(state), 32'd0);
    endtask

    initial begin
        logic [7:0] sclk_seq;
        logic [7:0] sclk_exp;
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sclk_seq;
        logic [7:0] sclk_exp;
        rst_n = 1'b0;
        hif.start = 1'b0;
        hif.skip_reset = 1'b0;
        hif.pattern = '0;
        chain = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_outs", {27'd0, scan_din, scan_reset, hif.busy, hif.done, scan_clk},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("rst_cap", 32'(hif.capture), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            sclk_seq[e-1] = scan_clk;
            sclk_exp[e-1] = ((e / 2) % 2) == 1;
        end
        check("sclk_seq", 32'(sclk_seq), 32'(sclk_exp));

        // chain preloaded with A5; 1C goes in, then FF with skip reads 1C back
        run_op(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_op(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, -1);

        // starts during busy are dropped
        run_op(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, -1);
        repeat (16) @(negedge clk);
        check("no_queue_busy", 32'(hif.busy), 32'd0);
        check("no_queue_done", done_cnt, 1);

        // start edge exactly on DONE->IDLE is kept
        run_op(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b1, -1);
        run_op(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // reset mid-shift, then a full operation
        run_op(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 4);
        run_op(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, -1);

        for (int n = 0; n < 6; n++)
            run_op(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
